// File: rtl/hpm_unit.sv
// Hardware performance monitor: programmable event counters 3..3+NCNT-1 with
// CSR read/write decode, privilege/counter-enable checks and overflow interrupt.
module hpm_unit #(
    parameter int NCNT = 8,
    parameter int NEVT = 16,
    parameter int CW   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rqst,
    input  logic [2:0]      func,
    input  logic [11:0]     addr,
    input  logic [63:0]     wdat,
    output logic [63:0]     rdat,
    input  logic [1:0]      level,
    input  logic [31:0]     in_inhibit,
    input  logic [31:0]     in_mcounteren,
    input  logic [31:0]     in_scounteren,
    input  logic [NEVT-1:0] evt,
    output logic            hit,
    output logic            eout,
    output logic            ovf,
    output logic            of_any
);

    logic [4:0]  idx;
    logic        rgn_mcnt;
    logic        rgn_ucnt;
    logic        rgn_evt;
    logic [63:0] wres;
    logic        priv_bad;
    logic        ucnt_bad;
    logic        wr_en;
    logic [255:0] evt_ext;

    logic [NCNT-1:0]        sel_hit;
    logic [NCNT-1:0]        of_vec;
    logic [NCNT-1:0]        wrap_new;
    logic [NCNT-1:0][63:0]  cnt64;
    logic [NCNT-1:0][63:0]  evt64;

    logic [34:0] unused_bits;
    assign unused_bits = {func[2], in_inhibit, level[1] & level[0], 1'b0};

    assign idx      = addr[4:0];
    assign rgn_mcnt = (addr[11:5] == 7'h58);
    assign rgn_ucnt = (addr[11:5] == 7'h60);
    assign rgn_evt  = (addr[11:5] == 7'h19);
    assign hit      = (idx >= 5'd3) && (rgn_mcnt || rgn_ucnt || rgn_evt);

    // Event k+1 lives at bit k+1, so select 0 and selects above NEVT hit a constant 0.
    assign evt_ext = 256'({evt, 1'b0});

    always_comb begin
        rdat = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (sel_hit[k]) begin
                if (rgn_mcnt || rgn_ucnt)
                    rdat = cnt64[k];
                else if (rgn_evt)
                    rdat = evt64[k];
            end
        end
    end

    always_comb begin
        case (func[1:0])
            2'b01:   wres = wdat;
            2'b10:   wres = rdat | wdat;
            2'b11:   wres = rdat & ~wdat;
            default: wres = rdat;
        endcase
    end

    assign priv_bad = (addr[9:8] > level);
    assign ucnt_bad = rgn_ucnt &&
                      ((wres != rdat) ||
                       ((level == 2'b01) && !in_mcounteren[idx]) ||
                       ((level == 2'b00) && (!in_mcounteren[idx] || !in_scounteren[idx])));
    assign eout     = rqst && (priv_bad || ucnt_bad);
    assign wr_en    = rqst && !eout && (func[1:0] != 2'b00);

    for (genvar g = 0; g < NCNT; g++) begin : g_ctr
        localparam int N = g + 3;

        logic [CW-1:0] cnt_q;
        logic [7:0]    sel_q;
        logic          of_q;
        logic          minh_q;
        logic          sinh_q;
        logic          uinh_q;
        logic          mode_inh;
        logic          inc;
        logic          cnt_wr;
        logic          evt_wr;

        assign sel_hit[g] = (idx == 5'(N));
        assign cnt_wr     = wr_en && rgn_mcnt && sel_hit[g];
        assign evt_wr     = wr_en && rgn_evt && sel_hit[g];

        assign mode_inh = ((level == 2'b11) && minh_q) ||
                          ((level == 2'b01) && sinh_q) ||
                          ((level == 2'b00) && uinh_q);
        assign inc      = evt_ext[sel_q] && !in_inhibit[N] && !mode_inh;

        // A CSR write to the counter or its event register owns the OF bit this cycle.
        assign wrap_new[g] = inc && (&cnt_q) && !cnt_wr && !evt_wr && !of_q;

        assign of_vec[g] = of_q;
        assign cnt64[g]  = 64'(cnt_q);
        assign evt64[g]  = {of_q, minh_q, sinh_q, uinh_q, 52'd0, sel_q};

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                sel_q  <= '0;
                of_q   <= 1'b0;
                minh_q <= 1'b0;
                sinh_q <= 1'b0;
                uinh_q <= 1'b0;
            end else begin
                if (cnt_wr)
                    cnt_q <= wres[CW-1:0];
                else if (inc)
                    cnt_q <= cnt_q + CW'(1);

                if (evt_wr) begin
                    sel_q  <= wres[7:0];
                    of_q   <= wres[63];
                    minh_q <= wres[62];
                    sinh_q <= wres[61];
                    uinh_q <= wres[60];
                end else if (inc && (&cnt_q) && !cnt_wr) begin
                    of_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else
            ovf <= |wrap_new;
    end

    assign of_any = |of_vec;

endmodule

// File: tb/tb_hpm_unit.sv
// Directed bench for hpm_unit (NCNT=8, NEVT=16, CW=32) with hand-computed expectations.
module tb_hpm_unit;

    logic        clk;
    logic        rst;
    logic        rqst;
    logic [2:0]  func;
    logic [11:0] addr;
    logic [63:0] wdat;
    logic [63:0] rdat;
    logic [1:0]  level;
    logic [31:0] in_inhibit;
    logic [31:0] in_mcounteren;
    logic [31:0] in_scounteren;
    logic [15:0] evt;
    logic        hit;
    logic        eout;
    logic        ovf;
    logic        of_any;

    int n_chk  = 0;
    int n_fail = 0;

    hpm_unit #(.NCNT(8), .NEVT(16), .CW(32)) dut (
        .clk(clk), .rst(rst), .rqst(rqst), .func(func), .addr(addr),
        .wdat(wdat), .rdat(rdat), .level(level), .in_inhibit(in_inhibit),
        .in_mcounteren(in_mcounteren), .in_scounteren(in_scounteren),
        .evt(evt), .hit(hit), .eout(eout), .ovf(ovf), .of_any(of_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] e, input int n);
        evt = e;
        tick(n);
        evt = '0;
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [63:0] d, output logic e);
        @(negedge clk);
        rqst = 1'b1;
        func = 3'b000;
        addr = a;
        wdat = '0;
        #1;
        d = rdat;
        e = eout;
        rqst = 1'b0;
    endtask

    task automatic csr_wr(input logic [2:0] f, input logic [11:0] a, input logic [63:0] d,
                          output logic e);
        @(negedge clk);
        rqst = 1'b1;
        func = f;
        addr = a;
        wdat = d;
        #1;
        e = eout;
        @(posedge clk);
        #1;
        rqst = 1'b0;
        func = 3'b000;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
        logic [63:0] d;
        logic        e;
        csr_rd(a, d, e);
        check(tag, d, exp);
    endtask

    task automatic hit_chk(input string tag, input logic [11:0] a, input logic exp);
        addr = a;
        #1;
        check(tag, 64'(hit), 64'(exp));
    endtask

    logic [63:0] d;
    logic        e;

    initial begin
        rst = 1'b1;
        rqst = 1'b0;
        func = '0;
        addr = '0;
        wdat = '0;
        level = 2'b11;
        in_inhibit = '0;
        in_mcounteren = '0;
        in_scounteren = '0;
        evt = '0;
        tick(3);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_of_any", 64'(of_any), 64'd0);
        rst = 1'b0;

        rd_chk("rst_cnt3", 12'hb03, 64'd0);
        rd_chk("rst_evt3", 12'h323, 64'd0);

        hit_chk("hit_b03", 12'hb03, 1'b1);
        hit_chk("hit_b02", 12'hb02, 1'b0);
        hit_chk("hit_33f", 12'h33f, 1'b1);
        hit_chk("hit_c1f", 12'hc1f, 1'b1);
        hit_chk("hit_c20", 12'hc20, 1'b0);

        // Basic counting: select event 1 on counter 3, five active cycles.
        csr_wr(3'b001, 12'h323, 64'd1, e);
        check("wr_evt3_eout", 64'(e), 64'd0);
        pulse(16'h0001, 5);
        rd_chk("count5", 12'hb03, 64'd5);

        // Select 17 is beyond NEVT: counter 4 never moves, counter 3 gets +3.
        csr_wr(3'b001, 12'h324, 64'd17, e);
        pulse(16'hffff, 3);
        rd_chk("sel_big_cnt4", 12'hb04, 64'd0);
        rd_chk("sel_all_cnt3", 12'hb03, 64'd8);

        // Writable-field mask; setting OF by write must not pulse ovf.
        csr_wr(3'b001, 12'h325, 64'hffff_ffff_ffff_ffff, e);
        check("of_wr_no_ovf", 64'(ovf), 64'd0);
        check("of_wr_any", 64'(of_any), 64'd1);
        rd_chk("evt5_mask", 12'h325, 64'hf000_0000_0000_00ff);
        csr_wr(3'b011, 12'h325, 64'hf000_0000_0000_0000, e);
        rd_chk("evt5_clr", 12'h325, 64'h0000_0000_0000_00ff);
        check("of_clr_any", 64'(of_any), 64'd0);

        // Write wins over a same-cycle increment.
        evt = 16'h0001;
        csr_wr(3'b001, 12'hb03, 64'h10, e);
        evt = '0;
        rd_chk("wr_vs_inc", 12'hb03, 64'h10);

        // Wrap from all ones: OF set, single ovf pulse; second wrap no pulse.
        csr_wr(3'b001, 12'hb03, 64'hffff_ffff, e);
        pulse(16'h0001, 1);
        check("wrap1_ovf", 64'(ovf), 64'd1);
        tick(1);
        check("wrap1_ovf_end", 64'(ovf), 64'd0);
        check("wrap1_of_any", 64'(of_any), 64'd1);
        rd_chk("wrap1_cnt", 12'hb03, 64'd0);
        rd_chk("wrap1_of", 12'h323, 64'h8000_0000_0000_0001);
        csr_wr(3'b001, 12'hb03, 64'hffff_ffff, e);
        pulse(16'h0001, 1);
        check("wrap2_no_ovf", 64'(ovf), 64'd0);
        rd_chk("wrap2_cnt", 12'hb03, 64'd0);
        csr_wr(3'b011, 12'h323, 64'h8000_0000_0000_0000, e);
        check("of_clear_any", 64'(of_any), 64'd0);

        // Two counters wrapping together give one pulse.
        csr_wr(3'b001, 12'h324, 64'd2, e);
        csr_wr(3'b001, 12'hb03, 64'hffff_ffff, e);
        csr_wr(3'b001, 12'hb04, 64'hffff_ffff, e);
        pulse(16'h0003, 1);
        check("dual_ovf", 64'(ovf), 64'd1);
        tick(1);
        check("dual_ovf_end", 64'(ovf), 64'd0);
        rd_chk("dual_cnt3", 12'hb03, 64'd0);
        rd_chk("dual_cnt4", 12'hb04, 64'd0);

        // Counter-enable checks on the user read-only view.
        csr_wr(3'b001, 12'hb04, 64'h1234, e);
        level = 2'b00;
        in_mcounteren = 32'h0000_0010;
        in_scounteren = 32'h0000_0000;
        csr_rd(12'hc04, d, e);
        check("u_scen0_eout", 64'(e), 64'd1);
        in_scounteren = 32'h0000_0010;
        csr_rd(12'hc04, d, e);
        check("u_scen1_eout", 64'(e), 64'd0);
        check("u_scen1_rdat", d, 64'h1234);
        level = 2'b01;
        in_mcounteren = '0;
        csr_rd(12'hc04, d, e);
        check("s_mcen0_eout", 64'(e), 64'd1);
        level = 2'b00;
        csr_rd(12'hb03, d, e);
        check("u_priv_eout", 64'(e), 64'd1);
        rqst = 1'b0;
        addr = 12'hb03;
        #1;
        check("norqst_eout", 64'(eout), 64'd0);

        // Set on read-only counter view is illegal when it would change the value.
        level = 2'b11;
        csr_wr(3'b010, 12'hc03, 64'd1, e);
        check("csrrs1_eout", 64'(e), 64'd1);
        rd_chk("csrrs1_cnt", 12'hb03, 64'd0);
        csr_wr(3'b010, 12'hc03, 64'd0, e);
        check("csrrs0_eout", 64'(e), 64'd0);

        // User-mode inhibit, then machine mode counts.
        csr_wr(3'b001, 12'h323, 64'h1000_0000_0000_0001, e);
        level = 2'b00;
        pulse(16'h0001, 3);
        level = 2'b11;
        rd_chk("uinh_cnt", 12'hb03, 64'd0);
        pulse(16'h0001, 2);
        rd_chk("m_cnt", 12'hb03, 64'd2);

        // Global inhibit bit.
        in_inhibit = 32'h0000_0008;
        pulse(16'h0001, 2);
        in_inhibit = '0;
        rd_chk("inhibit_cnt", 12'hb03, 64'd2);

        // Unimplemented index and func 00.
        csr_wr(3'b001, 12'hb1f, 64'd5, e);
        check("unimpl_eout", 64'(e), 64'd0);
        rd_chk("unimpl_rd", 12'hb1f, 64'd0);
        csr_wr(3'b000, 12'hb03, 64'h99, e);
        rd_chk("func0_cnt", 12'hb03, 64'd2);

        // Reset mid-count beats the increment.
        evt = 16'h0001;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        evt = '0;
        rd_chk("midrst_cnt", 12'hb03, 64'd0);
        rd_chk("midrst_evt", 12'h323, 64'd0);
        check("midrst_of_any", 64'(of_any), 64'd0);
        csr_wr(3'b001, 12'h323, 64'd1, e);
        pulse(16'h0001, 1);
        rd_chk("post_rst_cnt", 12'hb03, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hpm_unit.md
HPM_UNIT -- requirements
Module: hpm_unit

Interface
REQ-001 Parameter NCNT, default 8, number of implemented programmable counters (1..29), mapped to indices 3..3+NCNT-1.
REQ-002 Parameter NEVT, default 16, number of event inputs (1..255).
REQ-003 Parameter CW, default 64, counter width (32..64); bits 63:CW read 0.
REQ-004 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 rqst  in  1  CSR access request (this unit's address range only).
REQ-006 func  in  3  funct3; [1:0] 00 none, 01 write, 10 set, 11 clear.
REQ-007 addr  in  12  CSR address; wdat  in  64  write operand; rdat  out  64  read data.
REQ-008 level  in  2  privilege (00 U, 01 S, 11 M); in_inhibit  in  32  mcountinhibit.
REQ-009 in_mcounteren  in  32, in_scounteren  in  32  counter-enable masks.
REQ-010 evt  in  NEVT  per-cycle event pulses, evt[k] is event id k+1.
REQ-011 hit  out  1  addr is in 0xb03-0xb1f, 0x323-0x33f or 0xc03-0xc1f.
REQ-012 eout  out  1  illegal access; ovf  out  1  one-cycle overflow interrupt pulse; of_any  out  1  OR of all OF bits.

Function
REQ-013 mhpmeventN: [7:0] event select, [63] OF, [62] MINH, [61] SINH, [60] UINH; other bits read 0 and ignore writes.
REQ-014 Select 0 or >NEVT: counter never increments from events.
REQ-015 Counter i increments by 1 in cycle t when evt[sel-1]=1, in_inhibit[i]=0, and the mode-inhibit bit for level (MINH@11, SINH@01, UINH@00) is 0; new value visible in rdat at t+1.
REQ-016 Arithmetic modulo 2^CW; increment from 2^CW-1 yields 0.
REQ-017 On wrap, if OF=0: OF<=1 and ovf=1 in the next cycle; if OF already 1: OF stays 1, no ovf pulse.
REQ-018 Multiple counters wrapping in the same cycle produce a single ovf pulse.
REQ-019 rdat combinational from registered state: 0xb0N/0xc0N return counter N, 0x32N/0x33N return mhpmevent N; unimplemented indices read 0.
REQ-020 Write result wres = wdat | rdat | ~wdat&rdat per func as REQ-006; func 00 never writes.
REQ-021 Write to 0xb03+i loads counter with wres[CW-1:0]; same-cycle event increment discarded, no overflow.
REQ-022 Write to mhpmevent loads writable fields; a write setting OF=1 never pulses ovf; a write clearing OF in the wrap cycle leaves OF=0.
REQ-023 Writes to unimplemented indices ignored, no exception.
REQ-024 eout=1 if rqst and: addr[9:8] > level; or 0xc0N with wres != rdat; or 0xc0N at level 01 with in_mcounteren[N]=0; or at level 00 with in_mcounteren[N]=0 or in_scounteren[N]=0.
REQ-025 eout=1 suppresses all state change for that access; eout=0 when rqst=0.
REQ-026 hit purely combinational from addr, independent of rqst.
REQ-027 of_any combinational OR of OF bits of implemented counters.

Reset
REQ-028 During rst all counters and mhpmevent registers clear to 0; ovf=0; of_any=0.
REQ-029 rst asserted mid-count takes priority over increment, write and overflow in that cycle.
REQ-030 After rst deasserts, first increment possible in the following cycle.

Verification
REQ-031 Sel=1, level 11, evt[0] high 5 cycles -> counter 3 reads 5.
REQ-032 CW=32, counter preset 0xFFFFFFFF, one event -> reads 0, OF=1, ovf pulses once, of_any=1; second wrap -> no pulse.
REQ-033 level 00, mcounteren[4]=1, scounteren[4]=0, read 0xc04 -> eout=1; set scounteren[4] -> eout=0, rdat=counter 4.
REQ-034 Write 0xb03=0x10 in same cycle as event -> reads 0x10 next cycle.
REQ-035 UINH=1, level 00, events pulsed -> count unchanged; level 11 -> increments.
REQ-036 csrrs 0xc03 with wdat=1 -> eout=1, counter unchanged; csrrs wdat=0 -> eout=0.
